// File: rtl/dual_port_rom_reader.sv
// Dual-port ROM requester: two identical channels, each sweeping an address range,
// capturing ROM words after ROM_LATENCY and streaming them out with a running checksum.

module dual_port_rom_channel #(
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int ROM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH:0]   count,
  output logic                  cs,
  output logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] checksum
);

  localparam int WCW = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
  localparam logic [WCW-1:0]        WAIT_LAST = WCW'(ROM_LATENCY - 1);
  localparam logic [WCW-1:0]        WAIT_ONE  = WCW'(1);
  localparam logic [ADDR_WIDTH:0]   REM_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t                  state_r;
  logic [ADDR_WIDTH:0]     remaining_r;
  logic [WCW-1:0]          wait_cnt_r;
  logic                    cs_r;
  logic [ADDR_WIDTH-1:0]   address_r;
  logic                    out_valid_r;
  logic [DATA_WIDTH-1:0]   out_data_r;
  logic                    out_last_r;
  logic                    busy_r;
  logic                    done_r;
  logic [DATA_WIDTH-1:0]   checksum_r;

  function automatic logic [DATA_WIDTH-1:0] csum_add(
    input logic [DATA_WIDTH-1:0] acc,
    input logic [DATA_WIDTH-1:0] word
  );
    return acc + word;
  endfunction

  // Channel FSM; cs_r is raised on the edge entering REQ so it is high exactly while in REQ
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      remaining_r <= '0;
      wait_cnt_r  <= '0;
      cs_r        <= 1'b0;
      address_r   <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      checksum_r  <= '0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            checksum_r <= '0;
            if (count != '0) begin
              address_r   <= base;
              remaining_r <= count;
              busy_r      <= 1'b1;
              cs_r        <= 1'b1;
              state_r     <= REQ;
            end else begin
              done_r <= 1'b1;
            end
          end
        end
        REQ: begin
          cs_r       <= 1'b0;
          wait_cnt_r <= '0;
          state_r    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt_r == WAIT_LAST) begin
            out_data_r  <= rom_data;
            checksum_r  <= csum_add(checksum_r, rom_data);
            out_valid_r <= 1'b1;
            out_last_r  <= (remaining_r == REM_ONE);
            state_r     <= HOLD;
          end else begin
            wait_cnt_r <= wait_cnt_r + WAIT_ONE;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            remaining_r <= remaining_r - REM_ONE;
            if (remaining_r != REM_ONE) begin
              address_r <= address_r + ADDR_ONE;
              cs_r      <= 1'b1;
              state_r   <= REQ;
            end else begin
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= IDLE;
            end
          end
        end
        default: begin
          cs_r        <= 1'b0;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign cs        = cs_r;
  assign address   = address_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_last  = out_last_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign checksum  = checksum_r;

endmodule

module dual_port_rom_reader #(
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int ROM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_0,
  input  logic [ADDR_WIDTH-1:0] base_0,
  input  logic [ADDR_WIDTH:0]   count_0,
  output logic                  cs_0,
  output logic [ADDR_WIDTH-1:0] address_0,
  input  logic [DATA_WIDTH-1:0] rom_data_0,
  output logic                  out_valid_0,
  input  logic                  out_ready_0,
  output logic [DATA_WIDTH-1:0] out_data_0,
  output logic                  out_last_0,
  output logic                  busy_0,
  output logic                  done_0,
  output logic [DATA_WIDTH-1:0] checksum_0,
  input  logic                  start_1,
  input  logic [ADDR_WIDTH-1:0] base_1,
  input  logic [ADDR_WIDTH:0]   count_1,
  output logic                  cs_1,
  output logic [ADDR_WIDTH-1:0] address_1,
  input  logic [DATA_WIDTH-1:0] rom_data_1,
  output logic                  out_valid_1,
  input  logic                  out_ready_1,
  output logic [DATA_WIDTH-1:0] out_data_1,
  output logic                  out_last_1,
  output logic                  busy_1,
  output logic                  done_1,
  output logic [DATA_WIDTH-1:0] checksum_1
);

  dual_port_rom_channel #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .ROM_LATENCY(ROM_LATENCY)
  ) u_ch0 (
    .clk(clk), .rst(rst), .start(start_0), .base(base_0), .count(count_0),
    .cs(cs_0), .address(address_0), .rom_data(rom_data_0),
    .out_valid(out_valid_0), .out_ready(out_ready_0), .out_data(out_data_0),
    .out_last(out_last_0), .busy(busy_0), .done(done_0), .checksum(checksum_0)
  );

  dual_port_rom_channel #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .ROM_LATENCY(ROM_LATENCY)
  ) u_ch1 (
    .clk(clk), .rst(rst), .start(start_1), .base(base_1), .count(count_1),
    .cs(cs_1), .address(address_1), .rom_data(rom_data_1),
    .out_valid(out_valid_1), .out_ready(out_ready_1), .out_data(out_data_1),
    .out_last(out_last_1), .busy(busy_1), .done(done_1), .checksum(checksum_1)
  );

endmodule

// File: tb/tb_dual_port_rom_reader.sv
// Bench for dual_port_rom_reader: ROM model mem[i]=8'h10+i with 1-cycle latency,
// table-driven scans on port 0 plus hand-written dual-port, backpressure and reset sequences.

module tb_dual_port_rom_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_0, start_1;
  logic [3:0] base_0, base_1;
  logic [4:0] count_0, count_1;
  logic       cs_0, cs_1;
  logic [3:0] address_0, address_1;
  logic [7:0] rom_data_0 = 8'hEE, rom_data_1 = 8'hEE;
  logic       out_valid_0, out_valid_1;
  logic       out_ready_0, out_ready_1;
  logic [7:0] out_data_0, out_data_1;
  logic       out_last_0, out_last_1;
  logic       busy_0, busy_1;
  logic       done_0, done_1;
  logic [7:0] checksum_0, checksum_1;

  int tests = 0;
  int fails = 0;

  dual_port_rom_reader #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .ROM_LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .start_0(start_0), .base_0(base_0), .count_0(count_0), .cs_0(cs_0), .address_0(address_0),
    .rom_data_0(rom_data_0), .out_valid_0(out_valid_0), .out_ready_0(out_ready_0),
    .out_data_0(out_data_0), .out_last_0(out_last_0), .busy_0(busy_0), .done_0(done_0),
    .checksum_0(checksum_0),
    .start_1(start_1), .base_1(base_1), .count_1(count_1), .cs_1(cs_1), .address_1(address_1),
    .rom_data_1(rom_data_1), .out_valid_1(out_valid_1), .out_ready_1(out_ready_1),
    .out_data_1(out_data_1), .out_last_1(out_last_1), .busy_1(busy_1), .done_1(done_1),
    .checksum_1(checksum_1)
  );

  always #5 clk = ~clk;

  // ROM model: data valid only in the cycle after a cs edge, garbage otherwise
  always @(posedge clk) begin
    rom_data_0 <= cs_0 ? (8'h10 + {4'h0, address_0}) : 8'hEE;
    rom_data_1 <= cs_1 ? (8'h10 + {4'h0, address_1}) : 8'hEE;
  end

  int         cyc = 0;
  int         cs_cnt0 = 0, cs_cnt1 = 0, done_cnt0 = 0, done_cnt1 = 0;
  logic [7:0] words0[$], words1[$];
  logic       lasts0[$], lasts1[$];
  logic [3:0] addrs0[$], addrs1[$];
  int         cs_cyc0[$];

  // Monitor: sampled mid-cycle; valid&&ready here means a handshake at the next edge
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (cs_0) begin cs_cnt0++; addrs0.push_back(address_0); cs_cyc0.push_back(cyc); end
      if (cs_1) begin cs_cnt1++; addrs1.push_back(address_1); end
      if (out_valid_0 && out_ready_0) begin words0.push_back(out_data_0); lasts0.push_back(out_last_0); end
      if (out_valid_1 && out_ready_1) begin words1.push_back(out_data_1); lasts1.push_back(out_last_1); end
      if (done_0) done_cnt0++;
      if (done_1) done_cnt1++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic clear_mon;
    words0.delete(); words1.delete(); lasts0.delete(); lasts1.delete();
    addrs0.delete(); addrs1.delete(); cs_cyc0.delete();
    cs_cnt0 = 0; cs_cnt1 = 0; done_cnt0 = 0; done_cnt1 = 0;
  endtask

  task automatic start0(input logic [3:0] b, input logic [4:0] c);
    start_0 = 1'b1; base_0 = b; count_0 = c;
    step;
    start_0 = 1'b0;
  endtask

  task automatic wait_done0(input string tag);
    int n = 0;
    while (!done_0 && n < 200) begin step; n++; end
    check({tag, "_done_timeout"}, {31'd0, done_0}, 32'd1);
  endtask

  task automatic verify(input int ch, input logic [3:0] b, input int c,
                        input logic [7:0] sum, input string tag);
    logic [7:0] w[$];
    logic       l[$];
    logic [3:0] a[$];
    int         dc, cc;
    logic [7:0] cks;
    logic       bz;
    repeat (3) step;
    if (ch == 0) begin
      w = words0; l = lasts0; a = addrs0; dc = done_cnt0; cc = cs_cnt0; cks = checksum_0; bz = busy_0;
    end else begin
      w = words1; l = lasts1; a = addrs1; dc = done_cnt1; cc = cs_cnt1; cks = checksum_1; bz = busy_1;
    end
    check({tag, "_nwords"}, w.size(), c);
    for (int i = 0; i < c && i < w.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), {24'd0, w[i]}, {24'd0, 8'h10 + {4'h0, 4'(b + i)}});
      check($sformatf("%s_last%0d", tag, i), {31'd0, l[i]}, (i == c - 1) ? 32'd1 : 32'd0);
      check($sformatf("%s_addr%0d", tag, i), {28'd0, a[i]}, {28'd0, 4'(b + i)});
    end
    check({tag, "_cs_count"}, cc, c);
    check({tag, "_done_count"}, dc, 1);
    check({tag, "_checksum"}, {24'd0, cks}, {24'd0, sum});
    check({tag, "_busy_after"}, {31'd0, bz}, 32'd0);
  endtask

  typedef struct {
    logic [3:0] base;
    logic [4:0] count;
    logic [7:0] sum;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'd0,  5'd16, 8'h78};
    vecs[1] = '{4'd2,  5'd3,  8'h39};
    vecs[2] = '{4'd15, 5'd1,  8'h1F};
    vecs[3] = '{4'd14, 5'd4,  8'h5E};
    vecs[4] = '{4'd8,  5'd16, 8'h78};

    rst = 1'b1;
    start_0 = 1'b0; start_1 = 1'b0; base_0 = '0; base_1 = '0; count_0 = '0; count_1 = '0;
    out_ready_0 = 1'b1; out_ready_1 = 1'b1;
    #1;
    check("reset_outputs", {cs_0, cs_1, out_valid_0, out_valid_1, out_last_0, out_last_1,
                            busy_0, busy_1, done_0, done_1, 22'd0}, 32'd0);
    check("reset_words", {address_0, out_data_0, checksum_0, checksum_1[3:0]}, 32'd0);
    repeat (2) step;
    rst = 1'b0;
    step;

    // Table-driven scans on port 0, ready held high
    for (int v = 0; v < 5; v++) begin
      clear_mon;
      start0(vecs[v].base, vecs[v].count);
      wait_done0($sformatf("vec%0d", v));
      verify(0, vecs[v].base, vecs[v].count, vecs[v].sum, $sformatf("vec%0d", v));
      if (vecs[v].count == 5'd16) begin
        for (int i = 1; i < cs_cyc0.size(); i++)
          check($sformatf("vec%0d_cs_spacing%0d", v, i), cs_cyc0[i] - cs_cyc0[i-1], 3);
      end
      if (v == 0) begin
        check("port1_idle_cs", cs_cnt1, 0);
        check("port1_idle_done", done_cnt1, 0);
      end
    end

    // Zero-length scan: done next cycle, no cs, checksum cleared
    clear_mon;
    start0(4'd5, 5'd0);
    check("zero_done_pulse", {31'd0, done_0}, 32'd1);
    check("zero_checksum", {24'd0, checksum_0}, 32'd0);
    step;
    check("zero_done_low", {31'd0, done_0}, 32'd0);
    repeat (3) step;
    check("zero_cs_count", cs_cnt0, 0);
    check("zero_done_count", done_cnt0, 1);
    check("zero_busy", {31'd0, busy_0}, 32'd0);

    // Both ports active at once
    clear_mon;
    start_0 = 1'b1; base_0 = 4'd2;  count_0 = 5'd3;
    start_1 = 1'b1; base_1 = 4'd14; count_1 = 5'd4;
    step;
    start_0 = 1'b0; start_1 = 1'b0;
    for (int n = 0; n < 100 && !(done_cnt0 != 0 && done_cnt1 != 0); n++) step;
    verify(0, 4'd2, 3, 8'h39, "dual_p0");
    verify(1, 4'd14, 4, 8'h5E, "dual_p1");

    // Backpressure on the first word
    clear_mon;
    out_ready_0 = 1'b0;
    start0(4'd0, 5'd2);
    for (int n = 0; n < 20 && !out_valid_0; n++) step;
    for (int k = 0; k < 5; k++) begin
      step;
      check($sformatf("bp_valid%0d", k), {31'd0, out_valid_0}, 32'd1);
      check($sformatf("bp_data%0d", k), {24'd0, out_data_0}, 32'h10);
      check($sformatf("bp_cs%0d", k), cs_cnt0, 1);
    end
    out_ready_0 = 1'b1;
    wait_done0("bp");
    verify(0, 4'd0, 2, 8'h21, "bp");

    // Start while busy is ignored
    clear_mon;
    start0(4'd0, 5'd4);
    repeat (2) step;
    start0(4'd9, 5'd2);
    wait_done0("busy_start");
    verify(0, 4'd0, 4, 8'h46, "busy_start");

    // Start in the same cycle as done
    clear_mon;
    start0(4'd0, 5'd2);
    wait_done0("b2b_first");
    start0(4'd4, 5'd2);
    wait_done0("b2b_second");
    repeat (3) step;
    check("b2b_nwords", words0.size(), 4);
    check("b2b_done_count", done_cnt0, 2);
    check("b2b_checksum", {24'd0, checksum_0}, 32'h29);

    // Reset during WAIT aborts silently
    clear_mon;
    start0(4'd0, 5'd8);
    for (int n = 0; n < 20 && !cs_0; n++) step;
    step;
    rst = 1'b1;
    #1;
    check("rst_mid_outputs", {cs_0, out_valid_0, out_last_0, busy_0, done_0, 27'd0}, 32'd0);
    check("rst_mid_words", {16'd0, out_data_0, checksum_0}, 32'd0);
    repeat (3) step;
    rst = 1'b0;
    clear_mon;
    repeat (6) step;
    check("rst_no_done", done_cnt0, 0);
    check("rst_no_cs", cs_cnt0, 0);
    start0(4'd0, 5'd8);
    wait_done0("after_rst");
    verify(0, 4'd0, 8, 8'h9C, "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
